// File: rtl/clk_rate_pkg.sv
// Shared types and constants for the clock-rate detector: FSM encoding,
// default nominal periods and the tolerance compare used by the classifier.
package clk_rate_pkg;

    localparam int PERIOD_W = 24;

    localparam int unsigned P0_DEFAULT      = 1000;
    localparam int unsigned P1_DEFAULT      = 2000;
    localparam int unsigned P2_DEFAULT      = 4000;
    localparam int unsigned P3_DEFAULT      = 8000;
    localparam int unsigned TIMEOUT_DEFAULT = 16000;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MEAS = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    // One extra bit keeps the absolute difference from wrapping near the counter maximum.
    function automatic logic within_tol(input logic [PERIOD_W-1:0] meas,
                                        input logic [PERIOD_W-1:0] nom);
        logic [PERIOD_W:0] a;
        logic [PERIOD_W:0] b;
        logic [PERIOD_W:0] diff;
        a    = {1'b0, meas};
        b    = {1'b0, nom};
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= (b >> 3));
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector; rise pulses for one clk_in cycle per input rising edge.
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= d;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
            rise    <= sync_q2 & ~prev_q;
        end
    end

endmodule

// File: rtl/clk_rate_detect.sv
// Measures the period of an asynchronous divided clock in clk_in cycles,
// classifies it against four nominal rates and locks after two agreeing periods.
module clk_rate_detect
    import clk_rate_pkg::*;
#(
    parameter int unsigned P0      = P0_DEFAULT,
    parameter int unsigned P1      = P1_DEFAULT,
    parameter int unsigned P2      = P2_DEFAULT,
    parameter int unsigned P3      = P3_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                sig_in,
    output logic [1:0]          rate_code,
    output logic                rate_valid,
    output logic                no_signal,
    output logic [PERIOD_W-1:0] period,
    output logic                err
);

    localparam logic [PERIOD_W-1:0] NOM0      = PERIOD_W'(P0);
    localparam logic [PERIOD_W-1:0] NOM1      = PERIOD_W'(P1);
    localparam logic [PERIOD_W-1:0] NOM2      = PERIOD_W'(P2);
    localparam logic [PERIOD_W-1:0] NOM3      = PERIOD_W'(P3);
    localparam logic [PERIOD_W-1:0] TIMEOUT_W = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;

    logic                edge_det;
    logic [PERIOD_W-1:0] cnt;
    state_t              state;
    logic [1:0]          prev_match;
    logic                prev_valid;
    logic                match_hit;
    logic [1:0]          match_code;
    logic                timeout_hit;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (sig_in),
        .rise   (edge_det)
    );

    // Loading 1 on the edge makes the value seen at the next edge equal the exact spacing.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= PERIOD_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    always_comb begin
        match_hit  = 1'b1;
        match_code = 2'd0;
        if (within_tol(cnt, NOM0)) begin
            match_code = 2'd0;
        end else if (within_tol(cnt, NOM1)) begin
            match_code = 2'd1;
        end else if (within_tol(cnt, NOM2)) begin
            match_code = 2'd2;
        end else if (within_tol(cnt, NOM3)) begin
            match_code = 2'd3;
        end else begin
            match_hit = 1'b0;
        end
    end

    assign timeout_hit = (cnt == TIMEOUT_W) && !edge_det;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            period     <= '0;
            rate_code  <= 2'd0;
            rate_valid <= 1'b0;
            err        <= 1'b0;
            no_signal  <= 1'b1;
            prev_match <= 2'd0;
            prev_valid <= 1'b0;
        end else begin
            err <= 1'b0;
            if (edge_det) begin
                no_signal <= 1'b0;
                if (state == S_WAIT) begin
                    state <= S_MEAS;
                end else begin
                    period <= cnt;
                    if (!match_hit) begin
                        err        <= 1'b1;
                        rate_valid <= 1'b0;
                        prev_valid <= 1'b0;
                        state      <= S_MEAS;
                    end else if (state == S_LOCK) begin
                        // rate_code keeps the old rate until a new one is confirmed
                        if (match_code != rate_code) begin
                            rate_valid <= 1'b0;
                            prev_match <= match_code;
                            prev_valid <= 1'b1;
                            state      <= S_MEAS;
                        end
                    end else if (prev_valid && (match_code == prev_match)) begin
                        state      <= S_LOCK;
                        rate_code  <= match_code;
                        rate_valid <= 1'b1;
                    end else begin
                        prev_match <= match_code;
                        prev_valid <= 1'b1;
                    end
                end
            end else if (timeout_hit && (state != S_WAIT)) begin
                no_signal  <= 1'b1;
                rate_valid <= 1'b0;
                prev_valid <= 1'b0;
                state      <= S_WAIT;
            end
        end
    end

endmodule
